wb_write_queue: RTL and testbench

- Write-side companion to the 32x32 register file.
- Accepts register write requests from two producers per cycle: slot 0 is the pipeline WB stage, slot 1 is the multi-cycle unit / late load return.
- Buffers requests in an in-order FIFO and drains one per cycle into the register file's single write port (We/Wr/D).
- Provides a forwarding lookup so ID-stage reads of Ra/Rb see values still pending in the queue.

---
 rtl/wb_write_queue.sv | 154 +++++++++++++++
 tb/tb_wb_write_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
//
// In-order write buffer that sits in front of the single write port of the
// 32x32 register file. Two producers can issue per cycle: slot 0 is the WB
// stage and slot 1 is the multi-cycle unit or a late load return. The queue
// drains one entry per cycle into We/Wr/D. A forwarding lookup lets ID-stage
// reads on Ra/Rb see data that has not reached the register file yet.
//
// Ports
//   Clk, Clr                 clock, synchronous active-high reset
//   In0Valid/In0Wr/In0D      write request, slot 0 (older of the pair)
//   In1Valid/In1Wr/In1D      write request, slot 1 (younger of the pair)
//   Stall                    fewer than two free entries, producers hold off
//   Overflow                 sticky, a request arrived while Stall was high
//   Ra/Rb                    forwarding lookup addresses
//   QaHit/QaFwd, QbHit/QbFwd youngest pending data for Ra/Rb
//   We/Wr/D                  register file write port (head entry)
//   Count                    occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          In0Valid,
    input  logic [4:0]    In0Wr,
    input  logic [31:0]   In0D,
    input  logic          In1Valid,
    input  logic [4:0]    In1Wr,
    input  logic [31:0]   In1D,
    output logic          Stall,
    output logic          Overflow,
    input  logic [4:0]    Ra,
    input  logic [4:0]    Rb,
    output logic          QaHit,
    output logic [31:0]   QaFwd,
    output logic          QbHit,
    output logic [31:0]   QbFwd,
    output logic          We,
    output logic [4:0]    Wr,
    output logic [31:0]   D,
    output logic [AW:0]   Count
);

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } fwd_t;

    logic [4:0]    ent_wr_q [DEPTH];
    logic [31:0]   ent_d_q  [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] tail1;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          req0, req1, acc0, acc1, deq;
    fwd_t          fwd_a, fwd_b;

    // Register 0 is hardwired, so writes to it are never real requests.
    assign req0  = In0Valid && (In0Wr != 5'd0);
    assign req1  = In1Valid && (In1Wr != 5'd0);
    assign Stall = count_q > (AW+1)'(DEPTH - 2);
    assign acc0  = req0 && !Stall;
    assign acc1  = req1 && !Stall;
    assign deq   = count_q != '0;

    // Slot 1 lands right behind slot 0 when both are accepted, else at tail.
    assign tail1 = tail_q + AW'(acc0);

    always_comb begin
        head_d  = head_q + AW'(deq);
        tail_d  = tail_q + AW'(acc0) + AW'(acc1);
        count_d = count_q + (AW+1)'(acc0) + (AW+1)'(acc1) - (AW+1)'(deq);
        ovf_d   = ovf_q | (Stall & (req0 | req1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: the entry storage has no reset; occupancy gates every read of it,
    // so clearing it would only cost flops. Clr still blocks the write.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            if (acc0) begin
                ent_wr_q[tail_q] <= In0Wr;
                ent_d_q[tail_q]  <= In0D;
            end
            if (acc1) begin
                ent_wr_q[tail1] <= In1Wr;
                ent_d_q[tail1]  <= In1D;
            end
        end
    end

    // Scan oldest to youngest so later matches win, then let the incoming
    // pair override in slot order; the result is the youngest pending value.
    function automatic fwd_t lookup(input logic [4:0] r);
        fwd_t          res;
        logic [AW-1:0] idx;
        res = '0;
        idx = '0;
        if (r != 5'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + AW'(i);
                if (((AW+1)'(i) < count_q) && (ent_wr_q[idx] == r)) begin
                    res.hit  = 1'b1;
                    res.data = ent_d_q[idx];
                end
            end
            if (acc0 && (In0Wr == r)) begin
                res.hit  = 1'b1;
                res.data = In0D;
            end
            if (acc1 && (In1Wr == r)) begin
                res.hit  = 1'b1;
                res.data = In1D;
            end
        end
        return res;
    endfunction

    always_comb begin
        fwd_a = lookup(Ra);
        fwd_b = lookup(Rb);
    end

    assign QaHit    = fwd_a.hit;
    assign QaFwd    = fwd_a.data;
    assign QbHit    = fwd_b.hit;
    assign QbFwd    = fwd_b.data;

    assign We       = deq;
    assign Wr       = deq ? ent_wr_q[head_q] : 5'd0;
    assign D        = deq ? ent_d_q[head_q]  : 32'd0;
    assign Count    = count_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_write_queue
//
// Directed bench for wb_write_queue (DEPTH=4). Each scenario task drives its
// own stimulus and compares outputs against hand-computed values. Inputs are
// changed 1 ns after a rising edge and outputs are sampled 1 ns later, well
// clear of the next edge.
// -----------------------------------------------------------------------------
module tb_wb_write_queue;

    logic        Clk;
    logic        Clr;
    logic        In0Valid;
    logic [4:0]  In0Wr;
    logic [31:0] In0D;
    logic        In1Valid;
    logic [4:0]  In1Wr;
    logic [31:0] In1D;
    logic        Stall;
    logic        Overflow;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic        QaHit;
    logic [31:0] QaFwd;
    logic        QbHit;
    logic [31:0] QbFwd;
    logic        We;
    logic [4:0]  Wr;
    logic [31:0] D;
    logic [2:0]  Count;

    int n_cmp = 0;
    int n_bad = 0;

    wb_write_queue #(.DEPTH(4), .AW(2)) dut (
        .Clk(Clk), .Clr(Clr),
        .In0Valid(In0Valid), .In0Wr(In0Wr), .In0D(In0D),
        .In1Valid(In1Valid), .In1Wr(In1Wr), .In1D(In1D),
        .Stall(Stall), .Overflow(Overflow),
        .Ra(Ra), .Rb(Rb),
        .QaHit(QaHit), .QaFwd(QaFwd), .QbHit(QbHit), .QbFwd(QbFwd),
        .We(We), .Wr(Wr), .D(D), .Count(Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        In0Valid = 1'b0; In0Wr = 5'd0; In0D = 32'd0;
        In1Valid = 1'b0; In1Wr = 5'd0; In1D = 32'd0;
    endtask

    task automatic issue0(input logic [4:0] wr, input logic [31:0] d);
        In0Valid = 1'b1; In0Wr = wr; In0D = d;
    endtask

    task automatic issue1(input logic [4:0] wr, input logic [31:0] d);
        In1Valid = 1'b1; In1Wr = wr; In1D = d;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        Clr = 1'b1;
        issue0(5'd7, 32'h0000_0077);
        tick();
        tick();
        Clr = 1'b0;
        idle_inputs();
        #1;
        n_cmp++;
        if (Count !== 3'd0) begin
            n_bad++; $display("FAIL reset_count: got %0d want 0", Count);
        end
        n_cmp++;
        if ({We, Stall, Overflow, QaHit, QbHit} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_flags: We/Stall/Ovf/QaHit/QbHit got %b want 00000",
                     {We, Stall, Overflow, QaHit, QbHit});
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_single_write();
        issue0(5'd5, 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({We, Wr, D, Count} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 3'd1}) begin
            n_bad++;
            $display("FAIL single_port: We=%b Wr=%0d D=%h Count=%0d want 1 5 deadbeef 1",
                     We, Wr, D, Count);
        end
        tick();
        n_cmp++;
        if ({We, Wr, D, Count} !== {1'b0, 5'd0, 32'd0, 3'd0}) begin
            n_bad++;
            $display("FAIL single_drained: We=%b Wr=%0d D=%h Count=%0d want 0 0 0 0",
                     We, Wr, D, Count);
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_dual_order();
        issue0(5'd3, 32'h11);
        issue1(5'd3, 32'h22);
        Ra = 5'd3;
        #1;
        n_cmp++;
        if ({QaHit, QaFwd} !== {1'b1, 32'h22}) begin
            n_bad++;
            $display("FAIL dual_fwd_incoming: hit=%b fwd=%h want 1 22", QaHit, QaFwd);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({QaHit, QaFwd} !== {1'b1, 32'h22}) begin
            n_bad++;
            $display("FAIL dual_fwd_stored: hit=%b fwd=%h want 1 22", QaHit, QaFwd);
        end
        n_cmp++;
        if ({We, Wr, D, Count} !== {1'b1, 5'd3, 32'h11, 3'd2}) begin
            n_bad++;
            $display("FAIL dual_first: We=%b Wr=%0d D=%h Count=%0d want 1 3 11 2",
                     We, Wr, D, Count);
        end
        tick();
        n_cmp++;
        if ({We, Wr, D, Count} !== {1'b1, 5'd3, 32'h22, 3'd1}) begin
            n_bad++;
            $display("FAIL dual_second: We=%b Wr=%0d D=%h Count=%0d want 1 3 22 1",
                     We, Wr, D, Count);
        end
        tick();
        n_cmp++;
        if ({We, Count, QaHit, QaFwd} !== {1'b0, 3'd0, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL dual_empty: We=%b Count=%0d hit=%b fwd=%h want 0 0 0 0",
                     We, Count, QaHit, QaFwd);
        end
        Ra = 5'd0;
    endtask

    // ---------------------------------------------------------------------
    // head/tail start at 3 here, so this run wraps both pointers.
    task automatic test_fill_stall_wrap();
        logic [4:0]  exp_wr [6];
        logic [31:0] exp_d  [6];
        logic [2:0]  exp_cnt [6];
        exp_wr  = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd7, 5'd8};
        exp_d   = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hB1, 32'hB2};

        issue0(5'd1, 32'hA1); issue1(5'd2, 32'hA2);
        tick();
        #1;
        n_cmp++;
        if ({Count, Stall, We, Wr, D} !== {3'd2, 1'b0, 1'b1, exp_wr[0], exp_d[0]}) begin
            n_bad++;
            $display("FAIL fill_1: Count=%0d Stall=%b We=%b Wr=%0d D=%h want 2 0 1 1 a1",
                     Count, Stall, We, Wr, D);
        end
        issue0(5'd4, 32'hA3); issue1(5'd6, 32'hA4);
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({Count, Stall, We, Wr, D} !== {3'd3, 1'b1, 1'b1, exp_wr[1], exp_d[1]}) begin
            n_bad++;
            $display("FAIL fill_2: Count=%0d Stall=%b We=%b Wr=%0d D=%h want 3 1 1 2 a2",
                     Count, Stall, We, Wr, D);
        end

        // Request while stalled: must not forward, must be dropped.
        issue0(5'd9, 32'h99);
        Ra = 5'd9;
        Rb = 5'd2;
        #1;
        n_cmp++;
        if ({QaHit, QbHit, QbFwd} !== {1'b0, 1'b1, 32'hA2}) begin
            n_bad++;
            $display("FAIL stall_fwd: QaHit=%b QbHit=%b QbFwd=%h want 0 1 a2",
                     QaHit, QbHit, QbFwd);
        end
        tick();
        idle_inputs();
        Ra = 5'd0;
        Rb = 5'd0;
        #1;
        n_cmp++;
        if ({Overflow, Count, Wr, D} !== {1'b1, 3'd2, exp_wr[2], exp_d[2]}) begin
            n_bad++;
            $display("FAIL overflow: Ovf=%b Count=%0d Wr=%0d D=%h want 1 2 4 a3",
                     Overflow, Count, Wr, D);
        end

        issue0(5'd7, 32'hB1); issue1(5'd8, 32'hB2);
        tick();
        idle_inputs();
        exp_cnt = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd1};
        for (int i = 3; i < 6; i++) begin
            #1;
            n_cmp++;
            if ({We, Wr, D, Count} !== {1'b1, exp_wr[i], exp_d[i], exp_cnt[i]}) begin
                n_bad++;
                $display("FAIL drain_%0d: We=%b Wr=%0d D=%h Count=%0d want 1 %0d %h %0d",
                         i, We, Wr, D, Count, exp_wr[i], exp_d[i], exp_cnt[i]);
            end
            tick();
        end
        #1;
        n_cmp++;
        if ({We, Count, Overflow, Stall} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL drain_done: We=%b Count=%0d Ovf=%b Stall=%b want 0 0 1 0",
                     We, Count, Overflow, Stall);
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_r0_filter();
        issue0(5'd0, 32'h55);
        Ra = 5'd0;
        #1;
        n_cmp++;
        if ({QaHit, QaFwd} !== {1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL r0_fwd: hit=%b fwd=%h want 0 0", QaHit, QaFwd);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({We, Count} !== {1'b0, 3'd0}) begin
            n_bad++;
            $display("FAIL r0_filter: We=%b Count=%0d want 0 0", We, Count);
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_mid();
        issue0(5'd10, 32'hC1); issue1(5'd11, 32'hC2);
        tick();
        issue0(5'd12, 32'hC3); issue1(5'd13, 32'hC4);
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (Count !== 3'd3) begin
            n_bad++; $display("FAIL mid_prefill: Count=%0d want 3", Count);
        end
        Clr = 1'b1;
        issue1(5'd14, 32'hC5);
        tick();
        Clr = 1'b0;
        idle_inputs();
        Ra = 5'd12;
        #1;
        n_cmp++;
        if ({Count, We, Wr, D, QaHit, Overflow} !==
            {3'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset: Count=%0d We=%b Wr=%0d D=%h QaHit=%b Ovf=%b want 0 0 0 0 0 0",
                     Count, We, Wr, D, QaHit, Overflow);
        end
        tick();
        n_cmp++;
        if ({We, Count} !== {1'b0, 3'd0}) begin
            n_bad++; $display("FAIL mid_idle: We=%b Count=%0d want 0 0", We, Count);
        end
        issue0(5'd15, 32'hE0);
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({We, Wr, D, Count} !== {1'b1, 5'd15, 32'hE0, 3'd1}) begin
            n_bad++;
            $display("FAIL mid_fresh: We=%b Wr=%0d D=%h Count=%0d want 1 15 e0 1",
                     We, Wr, D, Count);
        end
        tick();
        Ra = 5'd0;
    endtask

    // ---------------------------------------------------------------------
    initial begin
        Clr = 1'b1;
        Ra  = 5'd0;
        Rb  = 5'd0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_dual_order();
        test_fill_stall_wrap();
        test_r0_filter();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
